// File: rtl/pixel_reduce_pkg.sv
// Shared constants and FSM state encoding for the pixel range reducer.
package pixel_reduce_pkg;

    localparam int MODE_MAX  = 0;
    localparam int MODE_MIN  = 1;
    localparam int MODE_BOTH = 2;

    typedef enum logic [1:0] {
        ST_FOLD   = 2'd0,
        ST_EMIT_A = 2'd1,
        ST_EMIT_B = 2'd2
    } state_t;

endpackage

// File: rtl/pixel_cmp_sel.sv
// Strict greater-than or less-than compare, signed or unsigned by parameter.
module pixel_cmp_sel #(
    parameter int DATA_W = 16,
    parameter int SIGNED = 1,
    parameter int GT     = 1
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_hit
);

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [DATA_W-1:0] FLIP = {(SIGNED != 0), {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;

    assign w_a   = i_a ^ FLIP;
    assign w_b   = i_b ^ FLIP;
    assign o_hit = (GT != 0) ? (w_a > w_b) : (w_a < w_b);

endmodule

// File: rtl/pixel_range_reduce.sv
// Folds FRAME_LEN pixels into a max and/or min, then emits one or two result tokens.
module pixel_range_reduce
    import pixel_reduce_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 262144,
    parameter int SIGNED    = 1,
    parameter int MODE      = MODE_MAX
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] In1_DATA,
    input  logic              In1_SEND,
    input  logic [15:0]       In1_COUNT,
    output logic              In1_ACK,
    output logic [DATA_W-1:0] Out1_DATA,
    output logic              Out1_SEND,
    input  logic              Out1_RDY,
    input  logic              Out1_ACK,
    output logic [15:0]       Out1_COUNT,
    output logic [15:0]       frame_cnt,
    output state_t            o_state
);

    // Handshake: an input token moves when In1_SEND && In1_ACK at a rising edge
    // (ACK only in FOLD); a result moves when Out1_SEND (= Out1_RDY in EMIT states).
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_max;
    logic [DATA_W-1:0]   r_min;
    logic                r_first;
    logic [15:0]         r_frame_cnt;

    logic                w_accept;
    logic                w_send;
    logic [DATA_W-1:0]   w_data;
    logic                w_last;
    logic                w_gt;
    logic                w_lt;
    logic                w_frame_done;
    logic                w_unused;

    pixel_cmp_sel #(.DATA_W(DATA_W), .SIGNED(SIGNED), .GT(1)) u_cmp_max (
        .i_a   (In1_DATA),
        .i_b   (r_max),
        .o_hit (w_gt)
    );

    pixel_cmp_sel #(.DATA_W(DATA_W), .SIGNED(SIGNED), .GT(0)) u_cmp_min (
        .i_a   (In1_DATA),
        .i_b   (r_min),
        .o_hit (w_lt)
    );

    assign w_last       = (r_cnt == CNT_W'(FRAME_LEN - 1));
    assign w_frame_done = w_send && ((r_state == ST_EMIT_B) || (MODE != MODE_BOTH));
    assign w_unused     = ^{In1_COUNT, Out1_ACK};

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= ST_FOLD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FOLD:   if (w_accept && w_last) w_next = ST_EMIT_A;
            ST_EMIT_A: if (w_send) w_next = (MODE == MODE_BOTH) ? ST_EMIT_B : ST_FOLD;
            ST_EMIT_B: if (w_send) w_next = ST_FOLD;
            default:   w_next = ST_FOLD;
        endcase
    end

    always_comb begin
        w_accept = 1'b0;
        w_send   = 1'b0;
        w_data   = '0;
        case (r_state)
            ST_FOLD: begin
                w_accept = RESET && In1_SEND;
            end
            ST_EMIT_A: begin
                w_send = RESET && Out1_RDY;
                w_data = w_send ? ((MODE == MODE_MIN) ? r_min : r_max) : '0;
            end
            ST_EMIT_B: begin
                w_send = RESET && Out1_RDY;
                w_data = w_send ? r_min : '0;
            end
            default: begin
                w_accept = 1'b0;
            end
        endcase
    end

    // The first token of a frame seeds both accumulators regardless of compare.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_cnt       <= '0;
            r_max       <= '0;
            r_min       <= '0;
            r_first     <= 1'b1;
            r_frame_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
                r_first <= w_last;
                if (r_first || w_gt) r_max <= In1_DATA;
                if (r_first || w_lt) r_min <= In1_DATA;
            end
            if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign In1_ACK    = w_accept;
    assign Out1_SEND  = w_send;
    assign Out1_DATA  = w_data;
    assign Out1_COUNT = 16'd1;
    assign frame_cnt  = r_frame_cnt;
    assign o_state    = r_state;

endmodule

// File: tb/tb_pixel_range_reduce.sv
// Directed bench for pixel_range_reduce: four instances covering max, both, min and single-token frames.
module tb_pixel_range_reduce;
    import pixel_reduce_pkg::*;

    logic        CLK;
    logic        RESET;
    logic [15:0] In1_DATA;
    logic        In1_SEND;
    logic        Out1_RDY;
    logic [15:0] In1_COUNT;
    logic        Out1_ACK;

    logic        ack      [4];
    logic [15:0] out_data [4];
    logic        out_send [4];
    logic [15:0] out_cnt  [4];
    logic [15:0] fcnt     [4];
    state_t      st       [4];

    int n_tests;
    int n_fail;
    logic [15:0] exp_q[$];

    pixel_range_reduce #(.DATA_W(16), .FRAME_LEN(4), .SIGNED(1), .MODE(MODE_MAX)) u_max_s (
        .CLK(CLK), .RESET(RESET), .In1_DATA(In1_DATA), .In1_SEND(In1_SEND), .In1_COUNT(In1_COUNT),
        .In1_ACK(ack[0]), .Out1_DATA(out_data[0]), .Out1_SEND(out_send[0]), .Out1_RDY(Out1_RDY),
        .Out1_ACK(Out1_ACK), .Out1_COUNT(out_cnt[0]), .frame_cnt(fcnt[0]), .o_state(st[0])
    );

    pixel_range_reduce #(.DATA_W(16), .FRAME_LEN(4), .SIGNED(0), .MODE(MODE_BOTH)) u_both_u (
        .CLK(CLK), .RESET(RESET), .In1_DATA(In1_DATA), .In1_SEND(In1_SEND), .In1_COUNT(In1_COUNT),
        .In1_ACK(ack[1]), .Out1_DATA(out_data[1]), .Out1_SEND(out_send[1]), .Out1_RDY(Out1_RDY),
        .Out1_ACK(Out1_ACK), .Out1_COUNT(out_cnt[1]), .frame_cnt(fcnt[1]), .o_state(st[1])
    );

    pixel_range_reduce #(.DATA_W(16), .FRAME_LEN(4), .SIGNED(1), .MODE(MODE_MIN)) u_min_s (
        .CLK(CLK), .RESET(RESET), .In1_DATA(In1_DATA), .In1_SEND(In1_SEND), .In1_COUNT(In1_COUNT),
        .In1_ACK(ack[2]), .Out1_DATA(out_data[2]), .Out1_SEND(out_send[2]), .Out1_RDY(Out1_RDY),
        .Out1_ACK(Out1_ACK), .Out1_COUNT(out_cnt[2]), .frame_cnt(fcnt[2]), .o_state(st[2])
    );

    pixel_range_reduce #(.DATA_W(16), .FRAME_LEN(1), .SIGNED(1), .MODE(MODE_MAX)) u_len1 (
        .CLK(CLK), .RESET(RESET), .In1_DATA(In1_DATA), .In1_SEND(In1_SEND), .In1_COUNT(In1_COUNT),
        .In1_ACK(ack[3]), .Out1_DATA(out_data[3]), .Out1_SEND(out_send[3]), .Out1_RDY(Out1_RDY),
        .Out1_ACK(Out1_ACK), .Out1_COUNT(out_cnt[3]), .frame_cnt(fcnt[3]), .o_state(st[3])
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive at negedge, settle, leave the caller to sample before the next posedge
    task automatic step(input logic send, input logic [15:0] d, input logic rdy);
        @(negedge CLK);
        In1_SEND = send;
        In1_DATA = d;
        Out1_RDY = rdy;
        #1;
    endtask

    task automatic feed(input int k, input logic [15:0] d);
        step(1'b1, d, 1'b1);
        chk("feed_ack", {31'd0, ack[k]}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET    = 1'b0;
        In1_SEND = 1'b1;
        Out1_RDY = 1'b1;
        #1;
        chk("rst_ack0", {31'd0, ack[0]}, 32'd0);
        chk("rst_send0", {31'd0, out_send[0]}, 32'd0);
        @(negedge CLK);
        #1;
        chk("rst_ack1", {31'd0, ack[1]}, 32'd0);
        chk("rst_fcnt", {16'd0, fcnt[0]}, 32'd0);
        chk("rst_data", {16'd0, out_data[0]}, 32'd0);
        @(negedge CLK);
        RESET    = 1'b1;
        In1_SEND = 1'b0;
    endtask

    initial begin
        int idx;
        int sends;
        logic [15:0] vals [12];
        logic [15:0] exp_v;

        n_tests   = 0;
        n_fail    = 0;
        RESET     = 1'b0;
        In1_DATA  = '0;
        In1_SEND  = 1'b0;
        Out1_RDY  = 1'b0;
        In1_COUNT = 16'd7;
        Out1_ACK  = 1'b0;

        // reset state
        do_reset();
        step(1'b0, 16'h0, 1'b1);
        chk("idle_state", {30'd0, st[0]}, {30'd0, ST_FOLD});
        chk("idle_send", {31'd0, out_send[0]}, 32'd0);
        chk("out_count", {16'd0, out_cnt[0]}, 32'd1);

        // max, signed: 5, -2, 9, 3 -> 9
        do_reset();
        feed(0, 16'd5); feed(0, 16'hFFFE); feed(0, 16'd9); feed(0, 16'd3);
        step(1'b0, 16'h0, 1'b1);
        chk("max_send", {31'd0, out_send[0]}, 32'd1);
        chk("max_data", {16'd0, out_data[0]}, 32'd9);
        chk("max_ack_emit", {31'd0, ack[0]}, 32'd0);
        step(1'b0, 16'h0, 1'b1);
        chk("max_send_after", {31'd0, out_send[0]}, 32'd0);
        chk("max_data_idle", {16'd0, out_data[0]}, 32'd0);
        chk("max_fcnt", {16'd0, fcnt[0]}, 32'd1);

        // both, unsigned: same inputs -> FFFE then 3
        do_reset();
        feed(1, 16'd5); feed(1, 16'hFFFE); feed(1, 16'd9); feed(1, 16'd3);
        step(1'b1, 16'h1234, 1'b1);
        chk("both_send_a", {31'd0, out_send[1]}, 32'd1);
        chk("both_data_a", {16'd0, out_data[1]}, 32'hFFFE);
        chk("both_ack_a", {31'd0, ack[1]}, 32'd0);
        step(1'b1, 16'h1234, 1'b1);
        chk("both_send_b", {31'd0, out_send[1]}, 32'd1);
        chk("both_data_b", {16'd0, out_data[1]}, 32'd3);
        chk("both_ack_b", {31'd0, ack[1]}, 32'd0);
        step(1'b1, 16'h1234, 1'b1);
        chk("both_ack_fold", {31'd0, ack[1]}, 32'd1);
        chk("both_send_fold", {31'd0, out_send[1]}, 32'd0);
        chk("both_fcnt", {16'd0, fcnt[1]}, 32'd1);

        // min, signed with tie on the most negative value
        do_reset();
        feed(2, 16'h8000); feed(2, 16'h7FFF); feed(2, 16'h0000); feed(2, 16'h8000);
        step(1'b0, 16'h0, 1'b1);
        chk("min_send", {31'd0, out_send[2]}, 32'd1);
        chk("min_data", {16'd0, out_data[2]}, 32'h8000);

        // consumer stall holds the emit state and backpressures input
        do_reset();
        feed(0, 16'd1); feed(0, 16'd2); feed(0, 16'd3); feed(0, 16'd4);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'd7, 1'b0);
            chk("stall_send", {31'd0, out_send[0]}, 32'd0);
            chk("stall_ack", {31'd0, ack[0]}, 32'd0);
            chk("stall_data", {16'd0, out_data[0]}, 32'd0);
        end
        chk("stall_state", {30'd0, st[0]}, {30'd0, ST_EMIT_A});
        step(1'b1, 16'd7, 1'b1);
        chk("release_send", {31'd0, out_send[0]}, 32'd1);
        chk("release_data", {16'd0, out_data[0]}, 32'd4);
        chk("release_ack", {31'd0, ack[0]}, 32'd0);
        step(1'b1, 16'd7, 1'b1);
        chk("next_frame_ack", {31'd0, ack[0]}, 32'd1);
        chk("next_frame_send", {31'd0, out_send[0]}, 32'd0);
        chk("stall_fcnt", {16'd0, fcnt[0]}, 32'd1);

        // reset mid-frame discards the partial frame
        do_reset();
        feed(0, 16'd100); feed(0, 16'd200);
        do_reset();
        feed(0, 16'd1); feed(0, 16'd2); feed(0, 16'd3);
        step(1'b1, 16'd4, 1'b1);
        chk("abort_no_early", {31'd0, out_send[0]}, 32'd0);
        step(1'b0, 16'h0, 1'b1);
        chk("abort_send", {31'd0, out_send[0]}, 32'd1);
        chk("abort_data", {16'd0, out_data[0]}, 32'd4);

        // reset mid-emit discards the pending result
        do_reset();
        feed(0, 16'd50); feed(0, 16'd60); feed(0, 16'd70); feed(0, 16'd80);
        step(1'b0, 16'h0, 1'b0);
        chk("midemit_state", {30'd0, st[0]}, {30'd0, ST_EMIT_A});
        do_reset();
        step(1'b0, 16'h0, 1'b1);
        chk("midemit_send", {31'd0, out_send[0]}, 32'd0);
        chk("midemit_state2", {30'd0, st[0]}, {30'd0, ST_FOLD});
        chk("midemit_fcnt", {16'd0, fcnt[0]}, 32'd0);

        // single-token frames
        do_reset();
        step(1'b1, 16'h0055, 1'b1);
        chk("len1_ack0", {31'd0, ack[3]}, 32'd1);
        step(1'b1, 16'h0066, 1'b1);
        chk("len1_send0", {31'd0, out_send[3]}, 32'd1);
        chk("len1_data0", {16'd0, out_data[3]}, 32'h55);
        chk("len1_ack_emit", {31'd0, ack[3]}, 32'd0);
        step(1'b1, 16'h0066, 1'b1);
        chk("len1_ack1", {31'd0, ack[3]}, 32'd1);
        step(1'b0, 16'h0, 1'b1);
        chk("len1_send1", {31'd0, out_send[3]}, 32'd1);
        chk("len1_data1", {16'd0, out_data[3]}, 32'h66);
        step(1'b0, 16'h0, 1'b1);
        chk("len1_fcnt", {16'd0, fcnt[3]}, 32'd2);

        // three back-to-back frames with In1_SEND held high
        do_reset();
        vals = '{16'd10, 16'd40, 16'd20, 16'd30,
                 16'd7,  16'd3,  16'd9,  16'd1,
                 16'd100, 16'd200, 16'd150, 16'd50};
        exp_q = {16'd40, 16'd9, 16'd200};
        idx   = 0;
        sends = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (idx < 12) step(1'b1, vals[idx], 1'b1);
            else          step(1'b0, 16'h0, 1'b1);
            if (ack[0]) idx++;
            if (out_send[0]) begin
                sends++;
                if (exp_q.size() > 0) begin
                    exp_v = exp_q.pop_front();
                    chk("b2b_data", {16'd0, out_data[0]}, {16'd0, exp_v});
                end else begin
                    chk("b2b_extra_send", 32'd1, 32'd0);
                end
            end
        end
        chk("b2b_tokens", idx, 32'd12);
        chk("b2b_sends", sends, 32'd3);
        chk("b2b_fcnt", {16'd0, fcnt[0]}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_range_reduce.md
PIXEL_RANGE_REDUCE -- requirements
Module: pixel_range_reduce

Interface
REQ-001 Parameter DATA_W, default 16, pixel width in bits (2..32) SHALL apply to In1_DATA, Out1_DATA and accumulators.
REQ-002 Parameter FRAME_LEN, default 262144, tokens per frame (1..2^24) SHALL set the fold length.
REQ-003 Parameter SIGNED, default 1: 1 = two's-complement compare, 0 = unsigned.
REQ-004 Parameter MODE, default 0: 0 = max, 1 = min, 2 = max then min (two output tokens per frame).
REQ-005 CLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 RESET  in  1  reset, synchronous, active-low.
REQ-007 In1_DATA  in  DATA_W  input pixel.
REQ-008 In1_SEND  in  1  input token valid.
REQ-009 In1_COUNT  in  16  producer token count, ignored.
REQ-010 In1_ACK  out  1  token consumed this cycle.
REQ-011 Out1_DATA  out  DATA_W  reduced result.
REQ-012 Out1_SEND  out  1  result token issued this cycle.
REQ-013 Out1_RDY  in  1  consumer can accept a token.
REQ-014 Out1_ACK  in  1  ignored.
REQ-015 Out1_COUNT  out  16  constant 1.
REQ-016 frame_cnt  out  16  completed frames, wraps at 2^16.

Function
REQ-017 States: FOLD, EMIT_A, EMIT_B; EMIT_B reachable only when MODE=2.
REQ-018 In FOLD, In1_ACK SHALL equal In1_SEND (combinational); at most one token per cycle; in EMIT states, In1_ACK SHALL be 0 (backpressure).
REQ-019 Token counter width SHALL be clog2(FRAME_LEN+1) bits, incremented on each accepted token.
REQ-020 First accepted token of a frame SHALL load max_acc and min_acc directly; later tokens update max_acc if strictly greater, min_acc if strictly less (ties keep stored value).
REQ-021 Comparison SHALL follow SIGNED; e.g. SIGNED=1, DATA_W=16: 0x8000 < 0x7FFF.
REQ-022 On acceptance of token FRAME_LEN, counter SHALL clear and state SHALL go to EMIT_A next cycle; accumulators include that token.
REQ-023 In EMIT_A, Out1_SEND SHALL equal Out1_RDY (combinational); Out1_DATA = max_acc (MODE 0, 2) or min_acc (MODE 1).
REQ-024 When Out1_SEND in EMIT_A: MODE=2 -> EMIT_B, else -> FOLD with frame_cnt+1.
REQ-025 In EMIT_B, Out1_SEND = Out1_RDY, Out1_DATA = min_acc; on send -> FOLD, frame_cnt+1.
REQ-026 Out1_RDY low SHALL hold the EMIT state indefinitely, Out1_DATA stable.
REQ-027 Out1_DATA SHALL be 0 whenever Out1_SEND is 0.
REQ-028 FRAME_LEN=1 SHALL emit every accepted token as its own max/min.
REQ-029 Frames SHALL repeat indefinitely; no state carried between frames except frame_cnt.

Reset
REQ-030 RESET low at a clock edge SHALL force state FOLD, counter 0, accumulators 0, frame_cnt 0, first-token flag set; outputs In1_ACK=0 (if In1_SEND=0), Out1_SEND=0, Out1_DATA=0.
REQ-031 Reset mid-frame or mid-emit SHALL discard partial results; no token is emitted for the aborted frame.
REQ-032 While RESET is low, In1_ACK and Out1_SEND SHALL be 0.

Structure
REQ-033 Shared package pixel_reduce_pkg SHALL hold MODE constants (MODE_MAX, MODE_MIN, MODE_BOTH) and the state enumeration.
REQ-034 Sub-module pixel_cmp_sel SHALL implement the parametrised signed/unsigned greater/less compare; instantiated once per accumulator.

Verification (DATA_W=16, FRAME_LEN=4)
REQ-035 MODE=0, SIGNED=1, inputs 5, 0xFFFE, 9, 3, Out1_RDY=1 -> one Out1_SEND with 9, frame_cnt=1.
REQ-036 MODE=2, SIGNED=0, same inputs -> sends 0xFFFE then 3 on consecutive cycles; In1_ACK=0 both cycles.
REQ-037 MODE=1, SIGNED=1, inputs 0x8000, 0x7FFF, 0, 0x8000 -> sends 0x8000.
REQ-038 MODE=0, Out1_RDY low 10 cycles after frame -> no send, In1_ACK=0 despite In1_SEND=1; RDY high -> single send, next frame accepted.
REQ-039 RESET low after 2 tokens, then 4 tokens 1,2,3,4 -> single send of 4; aborted frame produces nothing.
REQ-040 Back-to-back 3 frames, In1_SEND held 1 -> 3 sends, frame_cnt=3, no token lost or duplicated.
